// File: rtl/timer_controller_pkg.sv
// Shared types and defaults for the countdown timer sequencing controller.
package timer_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam int unsigned CLK_HZ_DEFAULT = 50_000_000;

    // Bits needed to hold the values 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/timer_controller_if.sv
// Strobe/status bundle between the sequencing controller and the countdown datapath.
interface timer_controller_if;
    import timer_ctrl_pkg::*;

    logic   load;
    logic   dec_en;
    logic   count_zero;
    logic   running;
    logic   paused;
    logic   alarm;
    state_e state;

    modport master (
        output load, dec_en, running, paused, alarm, state,
        input  count_zero
    );

    modport slave (
        input  load, dec_en, running, paused, alarm, state,
        output count_zero
    );

endinterface

// File: rtl/timer_controller_debouncer.sv
// Key conditioner: 2-FF synchronizer, stable-level debouncer and a one-cycle
// pulse on each accepted press (debounced 1->0).
module button_debouncer
    import timer_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic level,
    output logic press
);

    localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          level_dly_q;
    logic          press_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronized key disagrees with the
    // accepted level; any agreement restarts the stability window.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) level_d = sync2_q;
            else                   cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            level_q     <= 1'b1;
            level_dly_q <= 1'b1;
            press_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= btn_n;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= level_dly_q & ~level_q;
            cnt_q       <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/timer_controller.sv
// Countdown timer sequencer: debounced keys, 1 Hz-style tick enable, load/decrement
// strobes to the datapath and a timed alarm after expiry.
module timer_controller
    import timer_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ       = CLK_HZ_DEFAULT,
    parameter int unsigned TICK_DIV     = CLK_HZ,
    parameter int unsigned DEBOUNCE_CYC = 1_000_000,
    parameter int unsigned ALARM_SECS   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_btn,
    input  logic               pause_btn,
    timer_controller_if.master dp
);

    localparam int unsigned   TW         = cnt_width(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam int unsigned   AW         = cnt_width(ALARM_SECS);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SECS - 1);

    logic start_ev, pause_ev;
    logic unused_start_lvl, unused_pause_lvl;

    button_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_start_db (
        .clk   (clk),
        .reset (reset),
        .btn_n (start_btn),
        .level (unused_start_lvl),
        .press (start_ev)
    );

    button_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_pause_db (
        .clk   (clk),
        .reset (reset),
        .btn_n (pause_btn),
        .level (unused_pause_lvl),
        .press (pause_ev)
    );

    state_e        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [AW-1:0] alm_q, alm_d;
    logic          load_q, load_d;
    logic          dec_en_q, dec_en_d;
    logic          running_q, running_d;
    logic          paused_q, paused_d;
    logic          alarm_q, alarm_d;
    logic          tick_wrap;

    assign tick_wrap = (tick_q == TICK_LAST);

    // Start beats everything; expiry beats pause so DONE is never delayed.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start_ev) state_d = LOAD;
            LOAD:  state_d = RUN;
            RUN: begin
                if      (start_ev)      state_d = LOAD;
                else if (dp.count_zero) state_d = DONE;
                else if (pause_ev)      state_d = PAUSE;
            end
            PAUSE: begin
                if      (start_ev) state_d = LOAD;
                else if (pause_ev) state_d = RUN;
            end
            DONE: begin
                if      (start_ev)                         state_d = LOAD;
                else if (tick_wrap && alm_q == ALARM_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Entering LOAD or DONE restarts the phase; PAUSE and IDLE hold it.
    always_comb begin
        tick_d = tick_q;
        if (state_d != state_q && (state_d == LOAD || state_d == DONE))
            tick_d = '0;
        else if (state_q == LOAD || state_q == RUN || state_q == DONE)
            tick_d = tick_wrap ? '0 : tick_q + 1'b1;

        alm_d = alm_q;
        if (state_d == DONE && state_q != DONE) alm_d = '0;
        else if (state_q == DONE && tick_wrap)  alm_d = alm_q + 1'b1;

        dec_en_d  = (state_q == RUN) && (state_d == RUN) && tick_wrap && !dp.count_zero;
        load_d    = (state_d == LOAD);
        running_d = (state_d == RUN);
        paused_d  = (state_d == PAUSE);
        alarm_d   = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            alm_q     <= '0;
            load_q    <= 1'b0;
            dec_en_q  <= 1'b0;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            alm_q     <= alm_d;
            load_q    <= load_d;
            dec_en_q  <= dec_en_d;
            running_q <= running_d;
            paused_q  <= paused_d;
            alarm_q   <= alarm_d;
        end
    end

    assign dp.load    = load_q;
    assign dp.dec_en  = dec_en_q;
    assign dp.running = running_q;
    assign dp.paused  = paused_q;
    assign dp.alarm   = alarm_q;
    assign dp.state   = state_q;

endmodule

// File: tb/tb_timer_controller.sv
// Directed bench for timer_controller with TICK_DIV=4, DEBOUNCE_CYC=3, ALARM_SECS=2.
module tb_timer_controller;
    import timer_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start_btn = 1'b1;
    logic pause_btn = 1'b1;
    logic [7:0] start_num = 8'd3;
    logic [7:0] cnt_q = 8'd0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int uf_cnt = 0;

    timer_controller_if dp_if ();

    timer_controller #(
        .TICK_DIV     (4),
        .DEBOUNCE_CYC (3),
        .ALARM_SECS   (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start_btn (start_btn),
        .pause_btn (pause_btn),
        .dp        (dp_if)
    );

    always #5 clk = ~clk;

    // Countdown register model of the datapath.
    always @(posedge clk) begin
        if (!reset)                           cnt_q <= 8'd0;
        else if (dp_if.load)                  cnt_q <= start_num;
        else if (dp_if.dec_en && cnt_q != 0)  cnt_q <= cnt_q - 8'd1;
    end
    assign dp_if.count_zero = (cnt_q == 8'd0);

    always @(negedge clk)
        if (reset && dp_if.dec_en && dp_if.count_zero) uf_cnt <= uf_cnt + 1;

    typedef struct {
        int         n;
        logic       s;
        logic       p;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [12];

    function automatic logic [7:0] mk(state_e st, logic ld, logic de, logic ru, logic pa, logic al);
        return {st, ld, de, ru, pa, al};
    endfunction

    function automatic vec_t v(int n, logic s, logic p, logic [7:0] e);
        vec_t r;
        r.n = n; r.s = s; r.p = p; r.exp = e;
        return r;
    endfunction

    function automatic logic [7:0] outs();
        return {dp_if.state, dp_if.load, dp_if.dec_en, dp_if.running, dp_if.paused, dp_if.alarm};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chkv(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic chks(input string nm, input state_e act, input state_e exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    // Leaves the bench in IDLE with keys released; cyc=0 is the next edge cycle.
    task automatic do_reset();
        reset = 1'b0;
        start_btn = 1'b1;
        pause_btn = 1'b1;
        repeat (5) begin
            step();
            chkv("reset_outs", outs(), mk(IDLE, 0, 0, 0, 0, 0));
        end
        reset = 1'b1;
        repeat (2) begin
            step();
            chkv("post_reset_outs", outs(), mk(IDLE, 0, 0, 0, 0, 0));
        end
        cyc = 0;
    endtask

    initial begin
        int n_ld;
        int ld_cyc;

        // Full countdown from 3: press held 10 cycles, load at +7, dec_en at +4/+8/+12
        // after LOAD, DONE one cycle after count_zero, alarm for 8 cycles.
        tbl[0]  = v(4, 1, 1, mk(IDLE,  0, 0, 0, 0, 0));
        tbl[1]  = v(6, 0, 1, mk(IDLE,  0, 0, 0, 0, 0));
        tbl[2]  = v(1, 0, 1, mk(LOAD,  1, 0, 0, 0, 0));
        tbl[3]  = v(3, 0, 1, mk(RUN,   0, 0, 1, 0, 0));
        tbl[4]  = v(1, 1, 1, mk(RUN,   0, 1, 1, 0, 0));
        tbl[5]  = v(3, 1, 1, mk(RUN,   0, 0, 1, 0, 0));
        tbl[6]  = v(1, 1, 1, mk(RUN,   0, 1, 1, 0, 0));
        tbl[7]  = v(3, 1, 1, mk(RUN,   0, 0, 1, 0, 0));
        tbl[8]  = v(1, 1, 1, mk(RUN,   0, 1, 1, 0, 0));
        tbl[9]  = v(1, 1, 1, mk(RUN,   0, 0, 1, 0, 0));
        tbl[10] = v(8, 1, 1, mk(DONE,  0, 0, 0, 0, 1));
        tbl[11] = v(3, 1, 1, mk(IDLE,  0, 0, 0, 0, 0));

        start_num = 8'd3;
        do_reset();
        for (int r = 0; r < 12; r++) begin
            for (int k = 0; k < tbl[r].n; k++) begin
                start_btn = tbl[r].s;
                pause_btn = tbl[r].p;
                step();
                chkv($sformatf("tbl%0d", r), outs(), tbl[r].exp);
            end
        end

        // Short glitches never reach the stability window.
        do_reset();
        n_ld = 0;
        for (int i = 0; i < 20; i++) begin
            start_btn = !(i == 0 || i == 2 || i == 4 || i == 5);
            step();
            if (dp_if.load) n_ld++;
        end
        chki("glitch_loads", n_ld, 0);
        chks("glitch_state", dp_if.state, IDLE);

        // 2-cycle pulse, one high cycle, then a steady press starting at edge 3.
        do_reset();
        n_ld = 0;
        ld_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            start_btn = !(i < 2 || (i >= 3 && i < 23));
            step();
            if (dp_if.load) begin
                n_ld++;
                ld_cyc = cyc;
            end
        end
        chki("pulse_loads", n_ld, 1);
        chki("pulse_load_cyc", ld_cyc, 10);

        // Pause event lands 2 cycles after the dec_en at 15; held, released,
        // pressed again (event at 46): next dec_en 2 cycles after resume.
        do_reset();
        for (int i = 0; i < 56; i++) begin
            start_btn = !(i < 10);
            pause_btn = !((i >= 11 && i < 31) || (i >= 40 && i < 50));
            step();
            chk1("pause_dec_en", dp_if.dec_en, (cyc == 11 || cyc == 15 || cyc == 48));
            chk1("pause_paused", dp_if.paused, (cyc >= 18 && cyc <= 46));
            if (cyc == 50) chks("pause_done", dp_if.state, DONE);
        end

        // Start and pause events on the same cycle during RUN restart the count.
        do_reset();
        for (int i = 0; i < 26; i++) begin
            start_btn = !(i < 4 || (i >= 10 && i < 20));
            pause_btn = !(i >= 10 && i < 20);
            step();
            chk1("both_paused", dp_if.paused, 1'b0);
            chk1("both_load", dp_if.load, (cyc == 7 || cyc == 17));
            if (cyc == 16) chks("both_pre", dp_if.state, RUN);
            if (cyc == 17) chks("both_restart", dp_if.state, LOAD);
            if (cyc == 18) chks("both_run", dp_if.state, RUN);
        end

        // Loading zero: LOAD, one RUN cycle, DONE with no decrement; reset in DONE.
        start_num = 8'd0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            start_btn = !(i < 4);
            step();
            chk1("zero_dec_en", dp_if.dec_en, 1'b0);
            chks("zero_state", dp_if.state,
                 (cyc < 7) ? IDLE : (cyc == 7) ? LOAD : (cyc == 8) ? RUN : DONE);
        end
        chk1("zero_alarm", dp_if.alarm, 1'b1);
        reset = 1'b0;
        step();
        chkv("reset_in_done", outs(), mk(IDLE, 0, 0, 0, 0, 0));
        reset = 1'b1;
        step();

        chki("no_underflow", uf_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
